// File: rtl/vigna_axi_ram.sv
// vigna_axi_ram: AXI4-lite slave RAM terminating the vigna native-to-AXI adapter.
// Write address and write data are captured independently into holding
// registers; the RAM write commits once both are held and no response is
// outstanding. Reads have one-cycle latency. Every access completes OKAY.
module vigna_axi_ram #(
    parameter int    MEM_WORDS_LOG2 = 12,
    parameter string INIT_FILE      = ""
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        mem_axi_awvalid,
    output logic        mem_axi_awready,
    input  logic [31:0] mem_axi_awaddr,
    input  logic [2:0]  mem_axi_awprot,

    input  logic        mem_axi_wvalid,
    output logic        mem_axi_wready,
    input  logic [31:0] mem_axi_wdata,
    input  logic [3:0]  mem_axi_wstrb,

    output logic        mem_axi_bvalid,
    input  logic        mem_axi_bready,

    input  logic        mem_axi_arvalid,
    output logic        mem_axi_arready,
    input  logic [31:0] mem_axi_araddr,
    input  logic [2:0]  mem_axi_arprot,

    output logic        mem_axi_rvalid,
    input  logic        mem_axi_rready,
    output logic [31:0] mem_axi_rdata
);

    localparam int DEPTH = 1 << MEM_WORDS_LOG2;

    logic [31:0] mem [DEPTH];

    logic                      aw_full;
    logic [MEM_WORDS_LOG2-1:0] aw_idx;
    logic                      w_full;
    logic [31:0]               w_data;
    logic [3:0]                w_strb;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic commit;

    logic [MEM_WORDS_LOG2-1:0] aw_addr_idx;
    logic [MEM_WORDS_LOG2-1:0] ar_addr_idx;

    // Byte-offset bits, upper address bits and prot are deliberately dropped.
    logic unused_bits;
    assign unused_bits = ^{mem_axi_awprot, mem_axi_arprot,
                           mem_axi_awaddr[31:MEM_WORDS_LOG2+2], mem_axi_awaddr[1:0],
                           mem_axi_araddr[31:MEM_WORDS_LOG2+2], mem_axi_araddr[1:0]};

    assign aw_addr_idx = mem_axi_awaddr[MEM_WORDS_LOG2+1:2];
    assign ar_addr_idx = mem_axi_araddr[MEM_WORDS_LOG2+1:2];

    // Readies come from state and reset only, never from the valid inputs.
    assign mem_axi_awready = !reset && !aw_full;
    assign mem_axi_wready  = !reset && !w_full;
    assign mem_axi_arready = !reset && !mem_axi_rvalid;

    assign aw_hs  = mem_axi_awvalid && mem_axi_awready;
    assign w_hs   = mem_axi_wvalid  && mem_axi_wready;
    assign ar_hs  = mem_axi_arvalid && mem_axi_arready;
    // Reset gating keeps a held but uncommitted write out of the RAM.
    assign commit = !reset && aw_full && w_full && !mem_axi_bvalid;

    // Write-address holding register.
    always_ff @(posedge clk) begin
        if (reset) begin
            aw_full <= 1'b0;
            aw_idx  <= '0;
        end else if (aw_hs) begin
            aw_full <= 1'b1;
            aw_idx  <= aw_addr_idx;
        end else if (commit) begin
            aw_full <= 1'b0;
        end
    end

    // Write-data holding register.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_full <= 1'b0;
            w_data <= '0;
            w_strb <= '0;
        end else if (w_hs) begin
            w_full <= 1'b1;
            w_data <= mem_axi_wdata;
            w_strb <= mem_axi_wstrb;
        end else if (commit) begin
            w_full <= 1'b0;
        end
    end

    // Write response: raised by the commit, dropped by the B handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_axi_bvalid <= 1'b0;
        end else if (commit) begin
            mem_axi_bvalid <= 1'b1;
        end else if (mem_axi_bready) begin
            mem_axi_bvalid <= 1'b0;
        end
    end

    // Byte-masked RAM write; RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_strb[i]) begin
                    mem[aw_idx][8*i +: 8] <= w_data[8*i +: 8];
                end
            end
        end
    end

    // Synchronous read; a same-edge commit is not visible (read-before-write).
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_axi_rvalid <= 1'b0;
            mem_axi_rdata  <= '0;
        end else if (ar_hs) begin
            mem_axi_rvalid <= 1'b1;
            mem_axi_rdata  <= mem[ar_addr_idx];
        end else if (mem_axi_rready) begin
            mem_axi_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vigna_axi_ram.sv
// Self-checking bench for vigna_axi_ram: reset checks, a table of directed
// accesses, hand-written corner sequences and a randomized run against a
// word-array reference model of the RAM.
module tb_vigna_axi_ram;

    logic        clk = 1'b0;
    logic        reset;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [2:0]  awprot, arprot;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference RAM: only words 0..255 are used; upper address bits alias.
    logic [31:0] model_mem [256];

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_cyc;
        int          w_cyc;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    vigna_axi_ram dut (
        .clk             (clk),
        .reset           (reset),
        .mem_axi_awvalid (awvalid),
        .mem_axi_awready (awready),
        .mem_axi_awaddr  (awaddr),
        .mem_axi_awprot  (awprot),
        .mem_axi_wvalid  (wvalid),
        .mem_axi_wready  (wready),
        .mem_axi_wdata   (wdata),
        .mem_axi_wstrb   (wstrb),
        .mem_axi_bvalid  (bvalid),
        .mem_axi_bready  (bready),
        .mem_axi_arvalid (arvalid),
        .mem_axi_arready (arready),
        .mem_axi_araddr  (araddr),
        .mem_axi_arprot  (arprot),
        .mem_axi_rvalid  (rvalid),
        .mem_axi_rready  (rready),
        .mem_axi_rdata   (rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Write with AW presented at cycle aw_cyc and W at cycle w_cyc; then ack.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_cyc, input int w_cyc, input bit checks);
        int last;
        last = (aw_cyc > w_cyc) ? aw_cyc : w_cyc;
        awaddr = a; wdata = d; wstrb = s;
        for (int c = 0; c <= last; c++) begin
            awvalid = (c == aw_cyc);
            wvalid  = (c == w_cyc);
            tick();
            awvalid = 1'b0;
            wvalid  = 1'b0;
            if (checks && c < last && c == w_cyc)  chk("wready_held", {31'b0, wready}, 32'd0);
            if (checks && c < last && c == aw_cyc) chk("awready_held", {31'b0, awready}, 32'd0);
        end
        if (checks) chk("bvalid_early", {31'b0, bvalid}, 32'd0);
        tick();
        if (checks) chk("bvalid_set", {31'b0, bvalid}, 32'd1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        if (checks) chk("bvalid_clr", {31'b0, bvalid}, 32'd0);
        model_mem[a[9:2]] = merge(model_mem[a[9:2]], d, s);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input int stall);
        logic [31:0] first;
        chk("arready_idle", {31'b0, arready}, 32'd1);
        araddr  = a;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("rvalid_set", {31'b0, rvalid}, 32'd1);
        chk("rdata", rdata, exp);
        first = rdata;
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("rvalid_stall", {31'b0, rvalid}, 32'd1);
            chk("rdata_stable", rdata, first);
            chk("arready_stall", {31'b0, arready}, 32'd0);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("rvalid_clr", {31'b0, rvalid}, 32'd0);
        chk("arready_back", {31'b0, arready}, 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = 0; wdata = 0; wstrb = 0; araddr = 0; awprot = 3'd0; arprot = 3'd0;

        vecs[0] = '{1, 32'h10,   32'hDEADBEEF, 4'hF, 0, 0, 32'h0};
        vecs[1] = '{0, 32'h10,   32'h0,        4'h0, 0, 0, 32'hDEADBEEF};
        vecs[2] = '{1, 32'h20,   32'h11223344, 4'hF, 3, 0, 32'h0};
        vecs[3] = '{1, 32'h20,   32'hAABBCCDD, 4'h5, 0, 2, 32'h0};
        vecs[4] = '{0, 32'h20,   32'h0,        4'h0, 0, 0, 32'h11BB33DD};
        vecs[5] = '{1, 32'h30,   32'h00000000, 4'hF, 0, 0, 32'h0};
        vecs[6] = '{1, 32'h30,   32'hFFFFFFFF, 4'h0, 1, 1, 32'h0};
        vecs[7] = '{0, 32'h33,   32'h0,        4'h0, 0, 0, 32'h00000000};
        vecs[8] = '{1, 32'h4044, 32'hCAFEF00D, 4'hA, 0, 0, 32'h0};
        vecs[9] = '{0, 32'h44,   32'h0,        4'h0, 0, 0, 32'hCA00F000};

        tick();
        chk("rst_awready", {31'b0, awready}, 32'd0);
        chk("rst_wready",  {31'b0, wready},  32'd0);
        chk("rst_arready", {31'b0, arready}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("rst_bvalid", {31'b0, bvalid}, 32'd0);
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_rdata",  rdata, 32'd0);
        chk("post_rst_awready", {31'b0, awready}, 32'd1);
        chk("post_rst_wready",  {31'b0, wready},  32'd1);

        // Give every modelled word a known value.
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = 32'h0;
            do_write(32'(i) << 2, 32'h0, 4'hF, 0, 0, 1'b0);
        end

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].is_wr)
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb,
                         vecs[i].aw_cyc, vecs[i].w_cyc, 1'b1);
            else
                do_read(vecs[i].addr, vecs[i].exp, 0);
        end

        // B backpressure: second write is held until the first response drains.
        do_write(32'h50, 32'h1, 4'hF, 0, 0, 1'b0);
        awaddr = 32'h50; wdata = 32'h1; wstrb = 4'hF;
        awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        tick();
        chk("bp_bvalid", {31'b0, bvalid}, 32'd1);
        awaddr = 32'h54; wdata = 32'h2; wstrb = 4'hF;
        awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        chk("bp_awready", {31'b0, awready}, 32'd0);
        chk("bp_wready",  {31'b0, wready},  32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_bvalid_hold", {31'b0, bvalid}, 32'd1);
        end
        bready = 1;
        tick();
        bready = 0;
        chk("bp_bvalid_drop", {31'b0, bvalid}, 32'd0);
        tick();
        chk("bp_bvalid_second", {31'b0, bvalid}, 32'd1);
        bready = 1;
        tick();
        bready = 0;
        chk("bp_bvalid_clr", {31'b0, bvalid}, 32'd0);
        model_mem[8'h14] = 32'h1;
        model_mem[8'h15] = 32'h2;
        do_read(32'h50, 32'h1, 0);
        do_read(32'h54, 32'h2, 0);

        // R backpressure.
        do_read(32'h10, 32'hDEADBEEF, 3);

        // Read captured on the commit edge sees the old word.
        awaddr = 32'h40; wdata = 32'h12345678; wstrb = 4'hF;
        awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        araddr = 32'h40; arvalid = 1;
        tick();
        arvalid = 0;
        chk("col_rvalid", {31'b0, rvalid}, 32'd1);
        chk("col_rdata_old", rdata, 32'h0);
        chk("col_bvalid", {31'b0, bvalid}, 32'd1);
        bready = 1; rready = 1;
        tick();
        bready = 0; rready = 0;
        model_mem[8'h10] = 32'h12345678;
        do_read(32'h4040, 32'h12345678, 0);

        // Reset between handshake and commit drops the write.
        awaddr = 32'h60; wdata = 32'h99; wstrb = 4'hF;
        awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        reset = 1;
        #1;
        chk("mid_rst_awready", {31'b0, awready}, 32'd0);
        chk("mid_rst_arready", {31'b0, arready}, 32'd0);
        tick();
        chk("mid_rst_bvalid", {31'b0, bvalid}, 32'd0);
        reset = 0;
        tick();
        chk("mid_rst_bvalid2", {31'b0, bvalid}, 32'd0);
        chk("mid_rst_awready2", {31'b0, awready}, 32'd1);
        do_read(32'h60, 32'h0, 0);

        // Randomized accesses against the model.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = $urandom & 32'hFFFF_C3FF;
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
            else
                do_read(a, model_mem[a[9:2]], $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
